// File: rtl/sys_defs.sv
// ============================================================================
// sys_defs : shared bus command encodings, address width and owner type
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef SD
`define SD
`endif

package sys_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } mem_owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_tag_owner_table.sv
// ============================================================================
// mem_tag_owner_table : records which cache owns each outstanding load tag
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_tag_owner_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 16,
  parameter int TAG_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  mem_owner_t       alloc_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic             ret_valid,
  output mem_owner_t       ret_owner
);

  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] is_dcache_q, is_dcache_d;

  assign ret_valid = !reset && (ret_tag != '0) && valid_q[ret_tag];
  assign ret_owner = is_dcache_q[ret_tag] ? OWNER_DCACHE : OWNER_ICACHE;

  // Return clears first so a same-cycle reallocation of that tag survives.
  always_comb begin
    valid_d     = valid_q;
    is_dcache_d = is_dcache_q;
    if (ret_tag != '0) begin
      valid_d[ret_tag] = 1'b0;
    end
    if (alloc_en && (alloc_tag != '0)) begin
      valid_d[alloc_tag]     = 1'b1;
      is_dcache_d[alloc_tag] = (alloc_owner == OWNER_DCACHE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= `SD '0;
      is_dcache_q <= `SD '0;
    end else begin
      valid_q     <= `SD valid_d;
      is_dcache_q <= `SD is_dcache_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && (ret_tag != '0)) begin
      assert (valid_q[ret_tag])
        else $warning("mem_tag_owner_table: return of unowned tag %0d dropped", ret_tag);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : icache/dcache arbitration onto one memory port, tag routing
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int NUM_TAGS     = 16,
  parameter int TAG_W        = $clog2(NUM_TAGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Icache2mem_command,
  input  logic [XLEN-1:0]  Icache2mem_addr,
  input  logic [1:0]       Dcache2mem_command,
  input  logic [XLEN-1:0]  Dcache2mem_addr,
  input  logic [63:0]      Dcache2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output logic [1:0]       proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [TAG_W-1:0] mem2Icache_response,
  output logic [63:0]      mem2Icache_data,
  output logic [TAG_W-1:0] mem2Icache_tag,
  output logic [TAG_W-1:0] mem2Dcache_response,
  output logic [63:0]      mem2Dcache_data,
  output logic [TAG_W-1:0] mem2Dcache_tag
);

  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                ic_req, dc_req;
  logic                grant_ic, grant_dc;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                alloc_en;
  mem_owner_t          alloc_owner;
  logic                ret_valid;
  mem_owner_t          ret_owner;

  assign ic_req = (Icache2mem_command != BUS_NONE);
  assign dc_req = (Dcache2mem_command != BUS_NONE);

  // Dcache has priority except when the icache has been starved long enough.
  assign grant_ic = !reset && ic_req && (!dc_req || (starve_q == STARVE_MAX));
  assign grant_dc = !reset && dc_req && !grant_ic;

  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    mem2Icache_response = '0;
    mem2Dcache_response = '0;
    if (grant_ic) begin
      proc2mem_command    = Icache2mem_command;
      proc2mem_addr       = Icache2mem_addr;
      mem2Icache_response = mem2proc_response;
    end else if (grant_dc) begin
      proc2mem_command    = Dcache2mem_command;
      proc2mem_addr       = Dcache2mem_addr;
      mem2Dcache_response = mem2proc_response;
      if (Dcache2mem_command == BUS_STORE) begin
        proc2mem_data = Dcache2mem_data;
      end
    end
  end

  always_comb begin
    starve_d = '0;
    if (ic_req && !grant_ic) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= `SD '0;
    end else begin
      starve_q <= `SD starve_d;
    end
  end

  // Only accepted loads occupy a tag; stores never return data.
  assign alloc_en = ((grant_ic && (Icache2mem_command == BUS_LOAD)) ||
                     (grant_dc && (Dcache2mem_command == BUS_LOAD))) &&
                    (mem2proc_response != '0);
  assign alloc_owner = grant_dc ? OWNER_DCACHE : OWNER_ICACHE;

  mem_tag_owner_table #(
    .NUM_TAGS (NUM_TAGS),
    .TAG_W    (TAG_W)
  ) u_owner_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response),
    .alloc_owner (alloc_owner),
    .ret_tag     (mem2proc_tag),
    .ret_valid   (ret_valid),
    .ret_owner   (ret_owner)
  );

  assign mem2Icache_tag  = (ret_valid && (ret_owner == OWNER_ICACHE)) ? mem2proc_tag : '0;
  assign mem2Dcache_tag  = (ret_valid && (ret_owner == OWNER_DCACHE)) ? mem2proc_tag : '0;
  assign mem2Icache_data = mem2proc_data;
  assign mem2Dcache_data = mem2proc_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed vector table plus randomized model comparison
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LD   = 2'd1;
  localparam logic [1:0] ST   = 2'd2;
  localparam int         LIMIT = 3;

  typedef struct {
    logic        rst;
    logic [1:0]  ic_cmd;
    logic [31:0] ic_addr;
    logic [1:0]  dc_cmd;
    logic [31:0] dc_addr;
    logic [63:0] dc_data;
    logic [3:0]  resp;
    logic [3:0]  rtag;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_pdata;
    logic [3:0]  e_iresp;
    logic [3:0]  e_dresp;
    logic [3:0]  e_itag;
    logic [3:0]  e_dtag;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  Icache2mem_command, Dcache2mem_command;
  logic [31:0] Icache2mem_addr, Dcache2mem_addr;
  logic [63:0] Dcache2mem_data, mem2proc_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data, mem2Icache_data, mem2Dcache_data;
  logic [3:0]  mem2Icache_response, mem2Icache_tag, mem2Dcache_response, mem2Dcache_tag;

  int checks   = 0;
  int failures = 0;

  // Reference state: starvation streak and owner per tag (0 none, 1 icache, 2 dcache).
  int m_starve;
  int m_own [16];

  vec_t vecs[$];

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock               (clock),
    .reset               (reset),
    .Icache2mem_command  (Icache2mem_command),
    .Icache2mem_addr     (Icache2mem_addr),
    .Dcache2mem_command  (Dcache2mem_command),
    .Dcache2mem_addr     (Dcache2mem_addr),
    .Dcache2mem_data     (Dcache2mem_data),
    .mem2proc_response   (mem2proc_response),
    .mem2proc_data       (mem2proc_data),
    .mem2proc_tag        (mem2proc_tag),
    .proc2mem_command    (proc2mem_command),
    .proc2mem_addr       (proc2mem_addr),
    .proc2mem_data       (proc2mem_data),
    .mem2Icache_response (mem2Icache_response),
    .mem2Icache_data     (mem2Icache_data),
    .mem2Icache_tag      (mem2Icache_tag),
    .mem2Dcache_response (mem2Dcache_response),
    .mem2Dcache_data     (mem2Dcache_data),
    .mem2Dcache_tag      (mem2Dcache_tag)
  );

  function automatic vec_t mk(logic r, logic [1:0] icc, logic [31:0] ica, logic [1:0] dcc,
                              logic [31:0] dca, logic [63:0] dcd, logic [3:0] rsp, logic [3:0] rt,
                              logic [1:0] ec, logic [31:0] ea, logic [63:0] ep, logic [3:0] eir,
                              logic [3:0] edr, logic [3:0] eit, logic [3:0] edt);
    vec_t v;
    v.rst = r; v.ic_cmd = icc; v.ic_addr = ica; v.dc_cmd = dcc; v.dc_addr = dca;
    v.dc_data = dcd; v.resp = rsp; v.rtag = rt; v.e_cmd = ec; v.e_addr = ea;
    v.e_pdata = ep; v.e_iresp = eir; v.e_dresp = edr; v.e_itag = eit; v.e_dtag = edt;
    return v;
  endfunction

  function automatic vec_t idle(logic [3:0] rt, logic [3:0] eit, logic [3:0] edt);
    return mk(1'b0, NONE, 0, NONE, 0, 0, 4'd0, rt, NONE, 0, 0, 4'd0, 4'd0, eit, edt);
  endfunction

  // Winner by the arbitration rules: 0 none, 1 icache, 2 dcache.
  function automatic int winner(vec_t v);
    bit ic = (v.ic_cmd != NONE);
    bit dc = (v.dc_cmd != NONE);
    if (v.rst) return 0;
    if (ic && dc) return (m_starve == LIMIT) ? 1 : 2;
    if (ic) return 1;
    if (dc) return 2;
    return 0;
  endfunction

  function automatic vec_t model_predict(vec_t v);
    vec_t o = v;
    int w = winner(v);
    o.e_cmd = NONE; o.e_addr = 0; o.e_pdata = 0;
    o.e_iresp = 0; o.e_dresp = 0; o.e_itag = 0; o.e_dtag = 0;
    if (w == 1) begin
      o.e_cmd = v.ic_cmd; o.e_addr = v.ic_addr; o.e_iresp = v.resp;
    end else if (w == 2) begin
      o.e_cmd = v.dc_cmd; o.e_addr = v.dc_addr; o.e_dresp = v.resp;
      if (v.dc_cmd == ST) o.e_pdata = v.dc_data;
    end
    if (!v.rst && v.rtag != 0) begin
      if (m_own[v.rtag] == 1) o.e_itag = v.rtag;
      if (m_own[v.rtag] == 2) o.e_dtag = v.rtag;
    end
    return o;
  endfunction

  task automatic model_commit(vec_t v);
    int w = winner(v);
    logic [1:0] cmd;
    if (v.rst) begin
      m_starve = 0;
      for (int t = 0; t < 16; t++) m_own[t] = 0;
    end else begin
      if (v.ic_cmd != NONE && w != 1) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else m_starve = 0;
      if (v.rtag != 0) m_own[v.rtag] = 0;
      cmd = (w == 1) ? v.ic_cmd : (w == 2) ? v.dc_cmd : NONE;
      if (w != 0 && cmd == LD && v.resp != 0) m_own[v.resp] = w;
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(vec_t v, logic [63:0] mdata);
    @(negedge clock);
    reset              = v.rst;
    Icache2mem_command = v.ic_cmd;
    Icache2mem_addr    = v.ic_addr;
    Dcache2mem_command = v.dc_cmd;
    Dcache2mem_addr    = v.dc_addr;
    Dcache2mem_data    = v.dc_data;
    mem2proc_response  = v.resp;
    mem2proc_tag       = v.rtag;
    mem2proc_data      = mdata;
    #1;
    chk("proc2mem_command",    {62'd0, proc2mem_command},    {62'd0, v.e_cmd});
    chk("proc2mem_addr",       {32'd0, proc2mem_addr},       {32'd0, v.e_addr});
    chk("proc2mem_data",       proc2mem_data,                v.e_pdata);
    chk("mem2Icache_response", {60'd0, mem2Icache_response}, {60'd0, v.e_iresp});
    chk("mem2Dcache_response", {60'd0, mem2Dcache_response}, {60'd0, v.e_dresp});
    chk("mem2Icache_tag",      {60'd0, mem2Icache_tag},      {60'd0, v.e_itag});
    chk("mem2Dcache_tag",      {60'd0, mem2Dcache_tag},      {60'd0, v.e_dtag});
    chk("mem2Icache_data",     mem2Icache_data,              mdata);
    chk("mem2Dcache_data",     mem2Dcache_data,              mdata);
    model_commit(v);
  endtask

  initial begin
    vec_t v;
    int   t;
    m_starve = 0;
    for (int i = 0; i < 16; i++) m_own[i] = 0;

    // reset, lone icache load, tag return
    vecs.push_back(mk(1, LD, 'h100, LD, 'h300, 0, 3, 3, NONE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, LD, 'h100, NONE, 0, 0, 3, 0, LD, 'h100, 0, 3, 0, 0, 0));
    vecs.push_back(idle(3, 3, 0));
    // sustained contention: dcache x3, icache, dcache
    vecs.push_back(mk(0, LD, 'h104, LD, 'h400, 0, 6, 0, LD, 'h400, 0, 0, 6, 0, 0));
    vecs.push_back(mk(0, LD, 'h104, LD, 'h400, 0, 7, 0, LD, 'h400, 0, 0, 7, 0, 0));
    vecs.push_back(mk(0, LD, 'h104, LD, 'h400, 0, 8, 0, LD, 'h400, 0, 0, 8, 0, 0));
    vecs.push_back(mk(0, LD, 'h104, LD, 'h400, 0, 9, 0, LD, 'h104, 0, 9, 0, 0, 0));
    vecs.push_back(mk(0, LD, 'h104, LD, 'h400, 0, 10, 0, LD, 'h400, 0, 0, 10, 0, 0));
    vecs.push_back(idle(9, 9, 0));
    vecs.push_back(idle(7, 0, 7));
    // store is not recorded
    vecs.push_back(mk(0, NONE, 0, ST, 'h200, 'hDEAD, 5, 0, ST, 'h200, 'hDEAD, 0, 5, 0, 0));
    vecs.push_back(idle(5, 0, 0));
    // same-cycle return and reallocation of tag 2
    vecs.push_back(mk(0, LD, 'h180, NONE, 0, 0, 2, 0, LD, 'h180, 0, 2, 0, 0, 0));
    vecs.push_back(mk(0, NONE, 0, LD, 'h500, 0, 2, 2, LD, 'h500, 0, 0, 2, 2, 0));
    vecs.push_back(idle(2, 0, 2));
    // outstanding 1 (icache) and 4 (dcache), then reset drops them
    vecs.push_back(mk(0, LD, 'h108, NONE, 0, 0, 1, 0, LD, 'h108, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, NONE, 0, LD, 'h600, 0, 4, 0, LD, 'h600, 0, 0, 4, 0, 0));
    vecs.push_back(mk(1, LD, 'h10C, ST, 'h700, 'hBEEF, 6, 1, NONE, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle(1, 0, 0));
    vecs.push_back(idle(4, 0, 0));
    vecs.push_back(idle(6, 0, 0));
    // rejected load retried
    vecs.push_back(mk(0, LD, 'h110, NONE, 0, 0, 0, 0, LD, 'h110, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, LD, 'h110, NONE, 0, 0, 11, 0, LD, 'h110, 0, 11, 0, 0, 0));
    vecs.push_back(idle(11, 11, 0));

    foreach (vecs[i]) run_vec(vecs[i], 64'hC0DE_0000_0000_0000 + 64'(i));

    for (int n = 0; n < 400; n++) begin
      v.rst     = ($urandom_range(0, 59) == 0);
      v.ic_cmd  = ($urandom_range(0, 2) != 0) ? LD : NONE;
      v.ic_addr = {$urandom(), 3'b000} & 32'hFFFF_FFF8;
      v.dc_cmd  = 2'($urandom_range(0, 2));
      v.dc_addr = $urandom();
      v.dc_data = {$urandom(), $urandom()};
      v.resp    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      t         = $urandom_range(1, 15);
      v.rtag    = ($urandom_range(0, 1) == 1 && m_own[t] != 0) ? 4'(t) : 4'd0;
      v         = model_predict(v);
      run_vec(v, {$urandom(), $urandom()});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
